mem_bus_responder: RTL and testbench

MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

---
 rtl/mem_bus_responder_if.sv | 25 ++
 rtl/mem_bus_responder.sv | 150 +++++++++++++++
 tb/tb_mem_bus_responder.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_responder_if.sv
// Request/response bus between a memory requester (master) and the line-based
// memory responder (slave).
interface mem_bus_responder_if #(
    parameter int unsigned BUS_DATA_WIDTH = 64,
    parameter int unsigned BUS_TAG_WIDTH  = 13
);
    logic                      bus_reqcyc;
    logic [BUS_DATA_WIDTH-1:0] bus_req;
    logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
    logic                      bus_respack;
    logic                      bus_reqack;
    logic                      bus_respcyc;
    logic [BUS_DATA_WIDTH-1:0] bus_resp;
    logic [BUS_TAG_WIDTH-1:0]  bus_resptag;

    modport master (
        output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        input  bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );

    modport slave (
        input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        output bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );
endinterface

// File: rtl/mem_bus_responder.sv
// Line-oriented memory responder: 8-beat critical-word-first read bursts,
// 8-beat line writes committed atomically and followed by an invalidate beat.
module mem_bus_responder #(
    parameter int unsigned BUS_DATA_WIDTH = 64,
    parameter int unsigned BUS_TAG_WIDTH  = 13,
    parameter int unsigned MEM_LINES      = 256,
    parameter int unsigned READ_LATENCY   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    mem_bus_responder_if.slave      bus,
    output logic                    busy
);
    localparam int unsigned LINE_W = $clog2(MEM_LINES);
    localparam logic [BUS_TAG_WIDTH-1:0] INVAL_TAG = BUS_TAG_WIDTH'(13'h0800);

    typedef enum logic [2:0] {
        IDLE, ACK, RD_WAIT, RD_BURST, WR_DATA, WR_COMMIT, INVAL
    } state_e;

    state_e                     state_q, state_d;
    logic [BUS_DATA_WIDTH-1:3]  addr_q, addr_d;
    logic [BUS_TAG_WIDTH-1:0]   tag_q, tag_d;
    logic [2:0]                 beat_q, beat_d;
    logic [3:0]                 lat_q, lat_d;
    logic [BUS_DATA_WIDTH-1:0]  wbuf_q [8];
    logic [BUS_DATA_WIDTH-1:0]  wbuf_d [8];
    logic                       reqack_q, reqack_d;
    logic                       respcyc_q, respcyc_d;
    logic                       busy_q, busy_d;
    logic [BUS_DATA_WIDTH-1:0]  resp_q, resp_d;
    logic [BUS_TAG_WIDTH-1:0]   resptag_q, resptag_d;

    // Backing store: not reset, survives aborted transactions.
    logic [BUS_DATA_WIDTH-1:0]  mem_q [MEM_LINES][8];
    logic [LINE_W-1:0]          line;
    logic [2:0]                 word;

    always_comb begin
        line = addr_q[6 +: LINE_W];
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        tag_d   = tag_q;
        beat_d  = beat_q;
        lat_d   = lat_q;
        wbuf_d  = wbuf_q;
        case (state_q)
            IDLE: begin
                if (bus.bus_reqcyc) begin
                    addr_d  = bus.bus_req[BUS_DATA_WIDTH-1:3];
                    tag_d   = bus.bus_reqtag;
                    beat_d  = '0;
                    state_d = ACK;
                end
            end
            ACK: begin
                if (tag_q[12]) begin
                    state_d = WR_DATA;
                end else begin
                    state_d = RD_WAIT;
                    lat_d   = 4'(READ_LATENCY);
                end
            end
            RD_WAIT: begin
                if (lat_q <= 4'd1) begin
                    lat_d   = '0;
                    state_d = RD_BURST;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            RD_BURST: begin
                if (bus.bus_respack) begin
                    beat_d = beat_q + 3'd1;
                    if (beat_q == 3'd7) state_d = IDLE;
                end
            end
            WR_DATA: begin
                if (bus.bus_reqcyc) begin
                    wbuf_d[beat_q] = bus.bus_req;
                    beat_d         = beat_q + 3'd1;
                    if (beat_q == 3'd7) state_d = WR_COMMIT;
                end
            end
            WR_COMMIT: state_d = INVAL;
            INVAL:     state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Outputs are registered, so they are decoded from the next state/beat.
    always_comb begin
        word      = addr_q[5:3] + beat_d;
        reqack_d  = (state_d == ACK);
        respcyc_d = (state_d == RD_BURST) || (state_d == INVAL);
        busy_d    = (state_d != IDLE);
        resp_d    = '0;
        resptag_d = '0;
        if (state_d == RD_BURST) begin
            resp_d    = mem_q[line][word];
            resptag_d = tag_q;
        end else if (state_d == INVAL) begin
            resp_d    = {addr_q[BUS_DATA_WIDTH-1:6], 6'b0};
            resptag_d = INVAL_TAG;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            tag_q     <= '0;
            beat_q    <= '0;
            lat_q     <= '0;
            for (int unsigned i = 0; i < 8; i++) wbuf_q[i] <= '0;
            reqack_q  <= 1'b0;
            respcyc_q <= 1'b0;
            busy_q    <= 1'b0;
            resp_q    <= '0;
            resptag_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            tag_q     <= tag_d;
            beat_q    <= beat_d;
            lat_q     <= lat_d;
            wbuf_q    <= wbuf_d;
            reqack_q  <= reqack_d;
            respcyc_q <= respcyc_d;
            busy_q    <= busy_d;
            resp_q    <= resp_d;
            resptag_q <= resptag_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == WR_COMMIT) begin
            for (int unsigned i = 0; i < 8; i++) mem_q[line][i] <= wbuf_q[i];
        end
    end

    assign bus.bus_reqack  = reqack_q;
    assign bus.bus_respcyc = respcyc_q;
    assign bus.bus_resp    = resp_q;
    assign bus.bus_resptag = resptag_q;
    assign busy            = busy_q;
endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: write/invalidate, wrapped reads,
// backpressure, write gaps, reset abort and held request.
module tb_mem_bus_responder;
    localparam int RL = 2;

    logic clk;
    logic reset;
    logic busy;
    int   n_cmp = 0;
    int   n_err = 0;

    mem_bus_responder_if #(.BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13)) bus_if ();

    mem_bus_responder #(
        .BUS_DATA_WIDTH(64),
        .BUS_TAG_WIDTH (13),
        .MEM_LINES     (256),
        .READ_LATENCY  (RL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_reqack"},  64'(bus_if.bus_reqack),  64'd0);
        check({name, "_respcyc"}, 64'(bus_if.bus_respcyc), 64'd0);
        check({name, "_resp"},    bus_if.bus_resp,         64'd0);
        check({name, "_resptag"}, 64'(bus_if.bus_resptag), 64'd0);
        check({name, "_busy"},    64'(busy),               64'd0);
    endtask

    // abort_at >= 0: assert reset asynchronously while that beat is on the bus.
    task automatic do_write(input logic [63:0] addr, input logic [63:0] data [8],
                            input int gap_cycles, input int abort_at);
        int n_inv;
        @(negedge clk);
        bus_if.bus_reqcyc = 1'b1;
        bus_if.bus_req    = addr;
        bus_if.bus_reqtag = 13'h1005;
        @(posedge clk);
        @(negedge clk);
        check("wr_reqack", 64'(bus_if.bus_reqack), 64'd1);
        bus_if.bus_reqcyc = 1'b0;
        bus_if.bus_req    = '0;
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 4) begin
                repeat (gap_cycles) begin
                    bus_if.bus_reqcyc = 1'b0;
                    @(posedge clk);
                    @(negedge clk);
                end
            end
            bus_if.bus_reqcyc = 1'b1;
            bus_if.bus_req    = data[i];
            if (i == abort_at) begin
                #2 reset = 1'b0;
                #1 check_idle_outputs("abort");
                @(posedge clk);
                @(negedge clk);
                reset = 1'b1;
                bus_if.bus_reqcyc = 1'b0;
                bus_if.bus_req    = '0;
                return;
            end
            @(posedge clk);
        end
        @(negedge clk);
        bus_if.bus_reqcyc = 1'b0;
        bus_if.bus_req    = '0;
        n_inv = 0;
        repeat (4) begin
            if (bus_if.bus_respcyc) begin
                n_inv++;
                check("inval_tag",  64'(bus_if.bus_resptag), 64'h0800);
                check("inval_resp", bus_if.bus_resp, addr & ~64'h3F);
            end
            @(negedge clk);
        end
        check("inval_pulses", 64'(n_inv), 64'd1);
    endtask

    task automatic do_read(input logic [63:0] addr, input logic [12:0] tagv,
                           input logic [63:0] exp [8], input int stall_beat,
                           input int stall_cycles, input bit hold);
        int lat, acks, beat, cyc, stall_left, guard;
        @(negedge clk);
        bus_if.bus_reqcyc = 1'b1;
        bus_if.bus_req    = addr;
        bus_if.bus_reqtag = tagv;
        @(posedge clk);
        @(negedge clk);
        lat  = 0;
        acks = 0;
        while (!bus_if.bus_respcyc && lat < 40) begin
            lat++;
            if (bus_if.bus_reqack) acks++;
            if (!hold) bus_if.bus_reqcyc = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
        lat++;
        check("rd_latency", 64'(lat), 64'(RL + 2));
        beat = 0; cyc = 0; guard = 0; stall_left = stall_cycles;
        while (beat < 8 && guard < 40) begin
            guard++;
            if (bus_if.bus_reqack) acks++;
            if (bus_if.bus_respcyc) begin
                cyc++;
                check("rd_data", bus_if.bus_resp, exp[beat]);
                check("rd_tag",  64'(bus_if.bus_resptag), 64'(tagv));
                if (beat == stall_beat && stall_left > 0) begin
                    bus_if.bus_respack = 1'b0;
                    stall_left--;
                end else begin
                    bus_if.bus_respack = 1'b1;
                    beat++;
                end
            end else begin
                bus_if.bus_respack = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
        end
        bus_if.bus_respack = 1'b0;
        check("rd_end_respcyc", 64'(bus_if.bus_respcyc), 64'd0);
        check("rd_end_resp",    bus_if.bus_resp, 64'd0);
        check("rd_end_tag",     64'(bus_if.bus_resptag), 64'd0);
        check("rd_respcyc_cnt", 64'(cyc), 64'(8 + stall_cycles));
        check("rd_ack_cnt",     64'(acks), 64'd1);
        if (hold) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_reack", 64'(bus_if.bus_reqack), 64'd1);
            bus_if.bus_reqcyc  = 1'b0;
            bus_if.bus_respack = 1'b1;
            guard = 0;
            while (busy && guard < 40) begin
                guard++;
                @(posedge clk);
                @(negedge clk);
            end
            bus_if.bus_respack = 1'b0;
            check("hold_drain", 64'(busy), 64'd0);
        end
    endtask

    logic [63:0] d1 [8];
    logic [63:0] d1_rot [8];
    logic [63:0] dc [8];
    logic [63:0] da [8];
    logic [63:0] db [8];

    initial begin
        for (int i = 0; i < 8; i++) begin
            d1[i]     = 64'(8'h11 * (i + 1));
            d1_rot[i] = 64'(8'h11 * (((i + 3) % 8) + 1));
            dc[i]     = 64'hC0DE_0000_0000_00C0 + 64'(i);
            da[i]     = 64'hAAAA_0000_0000_0000 + 64'(i);
            db[i]     = 64'hBBBB_0000_0000_0000 + 64'(i);
        end
        reset              = 1'b0;
        bus_if.bus_reqcyc  = 1'b0;
        bus_if.bus_req     = '0;
        bus_if.bus_reqtag  = '0;
        bus_if.bus_respack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b1;

        do_write(64'h1040, d1, 0, -1);
        do_read(64'h1040, 13'h0123, d1, -1, 0, 1'b0);
        do_read(64'h1058, 13'h0456, d1_rot, -1, 0, 1'b0);
        do_read(64'h5040, 13'h0055, d1, -1, 0, 1'b0);
        do_read(64'h1040, 13'h0789, d1, 2, 3, 1'b0);

        do_write(64'h0300, dc, 3, -1);
        do_read(64'h0300, 13'h0011, dc, -1, 0, 1'b0);

        do_write(64'h2000, da, 0, -1);
        do_write(64'h2000, db, 0, 4);
        do_read(64'h2000, 13'h0022, da, -1, 0, 1'b0);

        do_read(64'h1040, 13'h0033, d1, -1, 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
